// File: rtl/isif_frame_arb_pkg.sv
// Shared definitions for the two-source ISIF frame arbiter: FSM state
// encodings, the default per-frame beat limit and the beat counter width.
package isif_frame_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        FLUSH  = 2'd3
    } arb_state_e;

    // Largest frame, in beats, forwarded before a last is forced.
    localparam int ARB_MAX_BEATS = 2048;

    // Beat counter width; wide enough to count up to ARB_MAX_BEATS-1.
    localparam int BEAT_CNT_W = 11;

endpackage

// File: rtl/isif_frame_arb_rr_pick2.sv
// Two-way round-robin pick: chooses which requesting source gets the next
// grant, favouring the one that was not served most recently.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       grant_idx,
    output logic       grant_valid
);

    // Lone requester wins outright; on a tie the source not served last wins.
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ~last_served;
        end else if (req[1]) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/isif_frame_arb.sv
// Frame-level arbiter between two ISIF FIFO sources feeding one convertor.
// A grant is held for a whole frame; frames longer than MAX_BEATS are cut
// with a forced last and flagged, the remainder becoming a new frame.
module isif_frame_arb
    import isif_frame_arb_pkg::*;
#(
    parameter int TBITS     = 64,
    parameter int TBYTE     = 8,
    parameter int MAX_BEATS = ARB_MAX_BEATS
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [TBITS-1:0] s0_isif_data,
    input  logic [TBYTE-1:0] s0_isif_strb,
    input  logic             s0_isif_last,
    input  logic             s0_isif_empty_n,
    output logic             s0_isif_read,

    input  logic [TBITS-1:0] s1_isif_data,
    input  logic [TBYTE-1:0] s1_isif_strb,
    input  logic             s1_isif_last,
    input  logic             s1_isif_empty_n,
    output logic             s1_isif_read,

    output logic [TBITS-1:0] m_isif_data,
    output logic [TBYTE-1:0] m_isif_strb,
    output logic             m_isif_last,
    output logic             m_isif_user,
    output logic             m_isif_empty_n,
    input  logic             m_isif_read,

    input  logic             arb_enable,
    output logic [1:0]       current_state,
    output logic [15:0]      frame_cnt0,
    output logic [15:0]      frame_cnt1,
    output logic             err_overlen
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BEATS - 1);

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic                  last_served_q;
    logic [BEAT_CNT_W-1:0] beat_cnt_q;
    logic [15:0]           frame_cnt0_q;
    logic [15:0]           frame_cnt1_q;
    logic                  err_overlen_q;

    logic                  pick_idx;
    logic                  pick_valid;
    logic                  forced_last;
    logic                  src_last;
    logic                  beat_take;
    logic                  frame_done;
    logic                  overlen_cut;

    rr_pick2 u_pick (
        .req         ({s1_isif_empty_n, s0_isif_empty_n}),
        .last_served (last_served_q),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // Next-state, word mux and FIFO pops; everything is quiet while reset is held.
    always_comb begin
        state_d        = state_q;
        m_isif_data    = '0;
        m_isif_strb    = '0;
        m_isif_last    = 1'b0;
        m_isif_user    = 1'b0;
        m_isif_empty_n = 1'b0;
        s0_isif_read   = 1'b0;
        s1_isif_read   = 1'b0;
        src_last       = 1'b0;
        forced_last    = (beat_cnt_q == LAST_BEAT);

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (arb_enable && pick_valid) begin
                        state_d = pick_idx ? GRANT1 : GRANT0;
                    end
                end
                GRANT0: begin
                    m_isif_data    = s0_isif_data;
                    m_isif_strb    = s0_isif_strb;
                    src_last       = s0_isif_last;
                    m_isif_last    = s0_isif_last | forced_last;
                    m_isif_user    = 1'b0;
                    m_isif_empty_n = s0_isif_empty_n;
                    s0_isif_read   = m_isif_read & s0_isif_empty_n;
                    if (m_isif_read && s0_isif_empty_n && m_isif_last) begin
                        state_d = FLUSH;
                    end
                end
                GRANT1: begin
                    m_isif_data    = s1_isif_data;
                    m_isif_strb    = s1_isif_strb;
                    src_last       = s1_isif_last;
                    m_isif_last    = s1_isif_last | forced_last;
                    m_isif_user    = 1'b1;
                    m_isif_empty_n = s1_isif_empty_n;
                    s1_isif_read   = m_isif_read & s1_isif_empty_n;
                    if (m_isif_read && s1_isif_empty_n && m_isif_last) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        beat_take   = m_isif_read & m_isif_empty_n;
        frame_done  = beat_take & m_isif_last;
        overlen_cut = frame_done & forced_last & ~src_last;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat counting, round-robin history, frame counters and the sticky overlength flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_served_q <= 1'b1;
            beat_cnt_q    <= '0;
            frame_cnt0_q  <= '0;
            frame_cnt1_q  <= '0;
            err_overlen_q <= 1'b0;
        end else begin
            if ((state_q != GRANT0 && state_q != GRANT1) || frame_done) begin
                beat_cnt_q <= '0;
            end else if (beat_take) begin
                beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
            end

            if (frame_done) begin
                last_served_q <= (state_q == GRANT1);
                if (state_q == GRANT1) begin
                    frame_cnt1_q <= frame_cnt1_q + 16'd1;
                end else begin
                    frame_cnt0_q <= frame_cnt0_q + 16'd1;
                end
            end

            if (overlen_cut) begin
                err_overlen_q <= 1'b1;
            end
        end
    end

    assign current_state = reset ? 2'd0 : 2'(state_q);
    assign frame_cnt0    = frame_cnt0_q;
    assign frame_cnt1    = frame_cnt1_q;
    assign err_overlen   = err_overlen_q;

endmodule

// File: tb/tb_isif_frame_arb.sv
// Directed bench for isif_frame_arb: two modelled source FIFOs, a log of
// beats taken by the convertor, and hand-computed expectations per scenario.
module tb_isif_frame_arb;

    localparam int TBITS     = 64;
    localparam int TBYTE     = 8;
    localparam int MAX_BEATS = 8;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  s;
        logic        l;
    } word_t;

    logic             clk;
    logic             reset;
    logic [TBITS-1:0] s0_isif_data;
    logic [TBYTE-1:0] s0_isif_strb;
    logic             s0_isif_last;
    logic             s0_isif_empty_n;
    logic             s0_isif_read;
    logic [TBITS-1:0] s1_isif_data;
    logic [TBYTE-1:0] s1_isif_strb;
    logic             s1_isif_last;
    logic             s1_isif_empty_n;
    logic             s1_isif_read;
    logic [TBITS-1:0] m_isif_data;
    logic [TBYTE-1:0] m_isif_strb;
    logic             m_isif_last;
    logic             m_isif_user;
    logic             m_isif_empty_n;
    logic             m_isif_read;
    logic             arb_enable;
    logic [1:0]       current_state;
    logic [15:0]      frame_cnt0;
    logic [15:0]      frame_cnt1;
    logic             err_overlen;

    word_t       q0[$];
    word_t       q1[$];
    logic        hold0;
    logic [63:0] out_data[$];
    logic        out_last[$];
    logic        out_user[$];
    int          out_cyc[$];
    int          cyc;
    int          vectors;
    int          miscompares;
    logic        saw_s1_read;
    logic        state_ok;
    logic        stall_ok;

    isif_frame_arb #(
        .TBITS     (TBITS),
        .TBYTE     (TBYTE),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s0_isif_data    (s0_isif_data),
        .s0_isif_strb    (s0_isif_strb),
        .s0_isif_last    (s0_isif_last),
        .s0_isif_empty_n (s0_isif_empty_n),
        .s0_isif_read    (s0_isif_read),
        .s1_isif_data    (s1_isif_data),
        .s1_isif_strb    (s1_isif_strb),
        .s1_isif_last    (s1_isif_last),
        .s1_isif_empty_n (s1_isif_empty_n),
        .s1_isif_read    (s1_isif_read),
        .m_isif_data     (m_isif_data),
        .m_isif_strb     (m_isif_strb),
        .m_isif_last     (m_isif_last),
        .m_isif_user     (m_isif_user),
        .m_isif_empty_n  (m_isif_empty_n),
        .m_isif_read     (m_isif_read),
        .arb_enable      (arb_enable),
        .current_state   (current_state),
        .frame_cnt0      (frame_cnt0),
        .frame_cnt1      (frame_cnt1),
        .err_overlen     (err_overlen)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the directed sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic driveSources();
        s0_isif_empty_n = (q0.size() != 0) && !hold0;
        s1_isif_empty_n = (q1.size() != 0);
        if (q0.size() != 0) begin
            s0_isif_data = q0[0].d;
            s0_isif_strb = q0[0].s;
            s0_isif_last = q0[0].l;
        end else begin
            s0_isif_data = '0;
            s0_isif_strb = '0;
            s0_isif_last = 1'b0;
        end
        if (q1.size() != 0) begin
            s1_isif_data = q1[0].d;
            s1_isif_strb = q1[0].s;
            s1_isif_last = q1[0].l;
        end else begin
            s1_isif_data = '0;
            s1_isif_strb = '0;
            s1_isif_last = 1'b0;
        end
    endtask

    task automatic pushFrame(input int src, input logic [63:0] base, input int n);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.d = base + 64'(i);
            w.s = w.d[7:0];
            w.l = (i == n - 1);
            if (src == 0) q0.push_back(w);
            else          q1.push_back(w);
        end
    endtask

    task automatic clearLog();
        out_data.delete();
        out_last.delete();
        out_user.delete();
        out_cyc.delete();
    endtask

    // One clock: capture pops and taken beats before the edge, update FIFOs after it.
    task automatic applyStimulus();
        logic r0;
        logic r1;
        driveSources();
        #1;
        r0 = s0_isif_read;
        r1 = s1_isif_read;
        if (m_isif_read && m_isif_empty_n) begin
            out_data.push_back(m_isif_data);
            out_last.push_back(m_isif_last);
            out_user.push_back(m_isif_user);
            out_cyc.push_back(cyc + 1);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (r1) saw_s1_read = 1'b1;
        if (r0 && q0.size() != 0) void'(q0.pop_front());
        if (r1 && q1.size() != 0) void'(q1.pop_front());
        driveSources();
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        hold0       = 1'b0;
        saw_s1_read = 1'b0;
        reset       = 1'b1;
        arb_enable  = 1'b0;
        m_isif_read = 1'b0;
        driveSources();

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("rst_state", 64'(current_state), 64'd0);
        checkOutput("rst_read0", 64'(s0_isif_read), 64'd0);
        checkOutput("rst_read1", 64'(s1_isif_read), 64'd0);
        checkOutput("rst_empty_n", 64'(m_isif_empty_n), 64'd0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("post_rst_state", 64'(current_state), 64'd0);
        checkOutput("post_rst_fc0", 64'(frame_cnt0), 64'd0);
        checkOutput("post_rst_fc1", 64'(frame_cnt1), 64'd0);
        checkOutput("post_rst_err", 64'(err_overlen), 64'd0);

        // Scenario 1: single source, 4-beat frame
        $display("[TB] scenario 1: single source");
        clearLog();
        saw_s1_read = 1'b0;
        pushFrame(0, 64'hA5A5_0000_0000_1010, 4);
        arb_enable  = 1'b1;
        m_isif_read = 1'b0;
        applyStimulus();
        checkOutput("s1_grant_state", 64'(current_state), 64'd1);
        checkOutput("s1_empty_n", 64'(m_isif_empty_n), 64'd1);
        checkOutput("s1_user", 64'(m_isif_user), 64'd0);
        checkOutput("s1_data0", m_isif_data, 64'hA5A5_0000_0000_1010);
        checkOutput("s1_strb0", 64'(m_isif_strb), 64'h10);
        m_isif_read = 1'b1;
        for (int k = 0; k < 20 && out_data.size() < 4; k++) applyStimulus();
        checkOutput("s1_beats", 64'(out_data.size()), 64'd4);
        for (int i = 0; i < out_data.size(); i++) begin
            checkOutput("s1_data", out_data[i], 64'hA5A5_0000_0000_1010 + 64'(i));
            checkOutput("s1_last", 64'(out_last[i]), 64'(i == 3));
            checkOutput("s1_beat_user", 64'(out_user[i]), 64'd0);
        end
        checkOutput("s1_flush", 64'(current_state), 64'd3);
        applyStimulus();
        checkOutput("s1_idle", 64'(current_state), 64'd0);
        checkOutput("s1_idle_data", m_isif_data, 64'd0);
        checkOutput("s1_fc0", 64'(frame_cnt0), 64'd1);
        checkOutput("s1_no_s1_read", 64'(saw_s1_read), 64'd0);

        // Scenario 2: contention from reset, then a third frame back to s0
        $display("[TB] scenario 2: contention");
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        clearLog();
        pushFrame(0, 64'h2000, 2);
        pushFrame(1, 64'h3000, 2);
        pushFrame(0, 64'h4000, 2);
        arb_enable  = 1'b1;
        m_isif_read = 1'b1;
        for (int k = 0; k < 40 && out_data.size() < 6; k++) applyStimulus();
        checkOutput("s2_beats", 64'(out_data.size()), 64'd6);
        if (out_data.size() == 6) begin
            checkOutput("s2_d0", out_data[0], 64'h2000);
            checkOutput("s2_d1", out_data[1], 64'h2001);
            checkOutput("s2_d2", out_data[2], 64'h3000);
            checkOutput("s2_d3", out_data[3], 64'h3001);
            checkOutput("s2_d4", out_data[4], 64'h4000);
            checkOutput("s2_d5", out_data[5], 64'h4001);
            checkOutput("s2_u1", 64'(out_user[1]), 64'd0);
            checkOutput("s2_u2", 64'(out_user[2]), 64'd1);
            checkOutput("s2_u3", 64'(out_user[3]), 64'd1);
            checkOutput("s2_u4", 64'(out_user[4]), 64'd0);
            checkOutput("s2_last1", 64'(out_last[1]), 64'd1);
            checkOutput("s2_last2", 64'(out_last[2]), 64'd0);
            checkOutput("s2_back2back", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
            checkOutput("s2_turn01", 64'(out_cyc[2] - out_cyc[1]), 64'd3);
            checkOutput("s2_turn12", 64'(out_cyc[4] - out_cyc[3]), 64'd3);
        end
        checkOutput("s2_fc0", 64'(frame_cnt0), 64'd2);
        checkOutput("s2_fc1", 64'(frame_cnt1), 64'd1);
        applyStimulus();

        // Scenario 3: convertor toggles read, s0 empties mid-frame
        $display("[TB] scenario 3: stalls");
        clearLog();
        pushFrame(0, 64'h5000, 5);
        state_ok = 1'b1;
        stall_ok = 1'b1;
        for (int k = 0; k < 40 && out_data.size() < 5; k++) begin
            m_isif_read = (k % 2 == 1);
            hold0       = (k >= 5 && k <= 8);
            applyStimulus();
            if (out_data.size() < 5 && current_state !== 2'd1) state_ok = 1'b0;
            if (hold0 && m_isif_empty_n !== 1'b0) stall_ok = 1'b0;
        end
        hold0 = 1'b0;
        checkOutput("s3_beats", 64'(out_data.size()), 64'd5);
        for (int i = 0; i < out_data.size(); i++) begin
            checkOutput("s3_data", out_data[i], 64'h5000 + 64'(i));
            checkOutput("s3_last", 64'(out_last[i]), 64'(i == 4));
        end
        checkOutput("s3_grant_held", 64'(state_ok), 64'd1);
        checkOutput("s3_stall_empty", 64'(stall_ok), 64'd1);
        checkOutput("s3_flush", 64'(current_state), 64'd3);
        applyStimulus();
        checkOutput("s3_fc0", 64'(frame_cnt0), 64'd3);

        // Scenario 4: 10-beat frame against an 8-beat limit
        $display("[TB] scenario 4: overlength");
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        clearLog();
        checkOutput("s4_err_before", 64'(err_overlen), 64'd0);
        pushFrame(1, 64'h6000, 10);
        arb_enable  = 1'b1;
        m_isif_read = 1'b1;
        for (int k = 0; k < 60 && out_data.size() < 10; k++) applyStimulus();
        checkOutput("s4_beats", 64'(out_data.size()), 64'd10);
        for (int i = 0; i < out_data.size(); i++) begin
            checkOutput("s4_data", out_data[i], 64'h6000 + 64'(i));
            checkOutput("s4_last", 64'(out_last[i]), 64'(i == 7 || i == 9));
            checkOutput("s4_user", 64'(out_user[i]), 64'd1);
        end
        if (out_data.size() == 10) begin
            checkOutput("s4_regrant_gap", 64'(out_cyc[8] - out_cyc[7]), 64'd3);
        end
        checkOutput("s4_err", 64'(err_overlen), 64'd1);
        checkOutput("s4_fc1", 64'(frame_cnt1), 64'd2);
        checkOutput("s4_fc0", 64'(frame_cnt0), 64'd0);
        applyStimulus();

        // Scenario 5a: enable dropped mid-frame
        $display("[TB] scenario 5: enable and reset");
        clearLog();
        pushFrame(0, 64'h7000, 3);
        pushFrame(0, 64'h7100, 2);
        arb_enable  = 1'b1;
        m_isif_read = 1'b0;
        applyStimulus();
        checkOutput("s5_grant", 64'(current_state), 64'd1);
        arb_enable  = 1'b0;
        m_isif_read = 1'b1;
        for (int k = 0; k < 20 && out_data.size() < 3; k++) applyStimulus();
        checkOutput("s5_beats", 64'(out_data.size()), 64'd3);
        if (out_data.size() == 3) begin
            checkOutput("s5_last_data", out_data[2], 64'h7002);
            checkOutput("s5_last_flag", 64'(out_last[2]), 64'd1);
        end
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("s5_stay_idle", 64'(current_state), 64'd0);
        checkOutput("s5_idle_read0", 64'(s0_isif_read), 64'd0);
        checkOutput("s5_err_sticky", 64'(err_overlen), 64'd1);
        checkOutput("s5_fc0", 64'(frame_cnt0), 64'd1);

        // Scenario 5b: reset in the middle of a frame
        arb_enable  = 1'b1;
        m_isif_read = 1'b0;
        applyStimulus();
        checkOutput("s5b_grant", 64'(current_state), 64'd1);
        m_isif_read = 1'b1;
        applyStimulus();
        reset = 1'b1;
        driveSources();
        #1;
        checkOutput("s5b_in_rst_read0", 64'(s0_isif_read), 64'd0);
        checkOutput("s5b_in_rst_empty", 64'(m_isif_empty_n), 64'd0);
        checkOutput("s5b_in_rst_state", 64'(current_state), 64'd0);
        applyStimulus();
        reset = 1'b0;
        driveSources();
        #1;
        checkOutput("s5b_state", 64'(current_state), 64'd0);
        checkOutput("s5b_read0", 64'(s0_isif_read), 64'd0);
        checkOutput("s5b_read1", 64'(s1_isif_read), 64'd0);
        checkOutput("s5b_empty", 64'(m_isif_empty_n), 64'd0);
        checkOutput("s5b_fc0", 64'(frame_cnt0), 64'd0);
        checkOutput("s5b_fc1", 64'(frame_cnt1), 64'd0);
        checkOutput("s5b_err", 64'(err_overlen), 64'd0);
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
